// File: rtl/axi4_read_burst2lite.sv
// rtl/axi4_read_burst2lite.sv - AXI4 read burst to AXI4-lite single-beat read bridge
module axi4_read_burst2lite #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [LEN_W-1:0]  s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic [ID_W-1:0]   s_rid,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp
);
  localparam logic [2:0] MAX_SIZE    = 3'($clog2(DATA_W / 8));
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_adv;
  logic [ADDR_W-1:0] beat_bytes;
  logic [ADDR_W-1:0] wrap_mask;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [ID_W-1:0]   id_q;
  logic              ar_hs;
  logic              req_bad;
  logic              last_beat;
  logic              beat_done;
  logic              wrap_ok;

  assign s_arready = (state == IDLE) & ~reset;
  assign ar_hs     = s_arvalid & s_arready;
  assign req_bad   = (s_arburst == BURST_RSVD) | (s_arsize > MAX_SIZE);
  assign last_beat = (beat_q == len_q);
  assign m_araddr  = addr_q;
  // A beat retires on the upstream R handshake, whether real data or a synthesized error
  assign beat_done = ((state == DATA) & m_rvalid & s_rready) | ((state == ERR) & s_rready);

  // Address of the next beat; WRAP with a non power-of-two beat count falls back to INCR
  always_comb begin
    beat_bytes = ADDR_W'(1) << size_q;
    wrap_mask  = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    wrap_ok    = (burst_q == BURST_WRAP) &&
                 ((len_q == LEN_W'(1)) || (len_q == LEN_W'(3)) ||
                  (len_q == LEN_W'(7)) || (len_q == LEN_W'(15)));
    if (burst_q == BURST_FIXED) begin
      addr_adv = addr_q;
    end else if (wrap_ok) begin
      addr_adv = (addr_q & ~wrap_mask) | ((addr_q + beat_bytes) & wrap_mask);
    end else begin
      addr_adv = addr_q + beat_bytes;
    end
  end

  // State register; lite AR valid is a flop so it is glitch-free and held until accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      m_arvalid <= 1'b0;
    end else begin
      state     <= state_nxt;
      m_arvalid <= (state_nxt == ADDR);
    end
  end

  // Burst context capture and per-beat progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
    end else if (ar_hs) begin
      addr_q  <= s_araddr;
      len_q   <= s_arlen;
      beat_q  <= '0;
      size_q  <= s_arsize;
      burst_q <= s_arburst;
      id_q    <= s_arid;
    end else if (beat_done && !last_beat) begin
      beat_q <= beat_q + LEN_W'(1);
      addr_q <= addr_adv;
    end
  end

  // Next-state and R-channel outputs; DATA passes the lite R channel straight through
  always_comb begin
    state_nxt = state;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    s_rlast   = 1'b0;
    s_rid     = '0;
    m_rready  = 1'b0;
    case (state)
      IDLE: begin
        if (ar_hs) state_nxt = req_bad ? ERR : ADDR;
      end
      ADDR: begin
        if (m_arready) state_nxt = DATA;
      end
      DATA: begin
        s_rvalid = m_rvalid;
        m_rready = s_rready;
        s_rdata  = m_rdata;
        s_rresp  = m_rresp;
        s_rid    = id_q;
        s_rlast  = last_beat;
        if (beat_done) state_nxt = last_beat ? IDLE : ADDR;
      end
      ERR: begin
        s_rvalid = 1'b1;
        s_rresp  = RESP_SLVERR;
        s_rid    = id_q;
        s_rlast  = last_beat;
        if (beat_done && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi4_read_burst2lite.sv
// tb/tb_axi4_read_burst2lite.sv - scoreboard bench for axi4_read_burst2lite
module tb_axi4_read_burst2lite;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_araddr = '0;
  logic [3:0]  s_arid = '0;
  logic [7:0]  s_arlen = '0;
  logic [2:0]  s_arsize = '0;
  logic [1:0]  s_arburst = '0;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_araddr;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;

  axi4_read_burst2lite #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(8)) dut (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] id;
    logic       last;
    logic       err;
  } exp_r_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr[$];
  exp_r_t      exp_r[$];
  logic [33:0] lite_q[$];
  logic        active = 1'b0;
  int          cur_beats = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference address of beat i, computed directly from the burst rules
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input int len,
                                            input int sz, input logic [1:0] bu);
    longint unsigned av, bytes, total, base, off;
    av    = a;
    bytes = longint'(1) << sz;
    total = longint'(len + 1) * bytes;
    if (bu == 2'b00) return a;
    if (bu == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      base = av - (av % total);
      off  = ((av % total) + longint'(i) * bytes) % total;
      return 32'(base + off);
    end
    return 32'(av + longint'(i) * bytes);
  endfunction

  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int     t;
    logic   legal;
    exp_r_t e;
    @(posedge clock); #1;
    s_arvalid = 1'b1; s_araddr = a; s_arid = id; s_arlen = len; s_arsize = sz; s_arburst = bu;
    t = 0;
    @(negedge clock);
    while (!s_arready && t < 5000) begin
      @(negedge clock);
      t++;
    end
    if (!s_arready) begin
      checks++; errors++;
      $display("FAIL ar_handshake_timeout: got no s_arready, expected one within 5000 cycles");
    end else begin
      legal = (bu != 2'b11) && (sz <= 3'd2);
      for (int i = 0; i <= int'(len); i++) begin
        if (legal) exp_addr.push_back(beat_addr(a, i, int'(len), int'(sz), bu));
        e.id = id; e.last = (i == int'(len)); e.err = !legal;
        exp_r.push_back(e);
      end
    end
    @(posedge clock); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_r.size() != 0 || active) && t < 20000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 20000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_r.size());
    end
  endtask

  // Lite slave: random AR ready, random read latency, random data and occasional error response
  logic mar_f, mr_f, sl_pend = 1'b0;
  int   sl_wait = 0;
  always begin : lite_slave
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clock);
    mar_f = m_arvalid && m_arready;
    mr_f  = m_rvalid && m_rready;
    @(posedge clock); #1;
    if (reset) begin
      m_arready = 1'b0; m_rvalid = 1'b0; sl_pend = 1'b0;
    end else begin
      if (mr_f) m_rvalid = 1'b0;
      if (mar_f) begin sl_pend = 1'b1; sl_wait = $urandom_range(0, 3); end
      if (sl_pend && !m_rvalid) begin
        if (sl_wait == 0) begin
          d = $urandom;
          r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          m_rvalid = 1'b1; m_rdata = d; m_rresp = r;
          lite_q.push_back({r, d});
          sl_pend = 1'b0;
        end else begin
          sl_wait--;
        end
      end
      m_arready = ($urandom_range(0, 2) == 0);
    end
  end

  // Upstream R consumer with random backpressure
  always begin : r_consumer
    @(posedge clock); #1;
    s_rready = ($urandom_range(0, 9) < 6);
  end

  // Monitor: pops expectations whenever the DUT completes a handshake
  logic        lat_chk = 1'b0, hold_ar = 1'b0, hold_r = 1'b0, lite_out = 1'b0;
  logic [31:0] hold_ar_v;
  logic [39:0] hold_r_v;
  exp_r_t      mon_e;
  logic [33:0] mon_lv;
  always begin : monitor
    @(negedge clock);
    if (reset) begin
      exp_addr.delete(); exp_r.delete(); lite_q.delete();
      active = 1'b0; lat_chk = 1'b0; hold_ar = 1'b0; hold_r = 1'b0; lite_out = 1'b0;
      cur_beats = 0;
    end else begin
      chk("s_arready_vs_busy", s_arready, !active);
      if (lat_chk) chk("m_arvalid_t_plus_1", m_arvalid, 1);
      lat_chk = 1'b0;
      if (hold_ar) chk("m_ar_stable", {m_arvalid, m_araddr}, {1'b1, hold_ar_v});
      if (hold_r) chk("s_r_stable", {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata}, hold_r_v);
      hold_ar   = m_arvalid && !m_arready;
      hold_ar_v = m_araddr;
      hold_r    = s_rvalid && !s_rready;
      hold_r_v  = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata};
      if (m_arvalid && m_arready) begin
        chk("one_outstanding", lite_out, 0);
        lite_out = 1'b1;
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_lite_ar: got addr 0x%0h, expected no lite AR", m_araddr);
        end else begin
          chk("m_araddr", m_araddr, exp_addr.pop_front());
        end
      end
      if (m_rvalid && m_rready) lite_out = 1'b0;
      if (s_rvalid && s_rready) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_r_beat: got data 0x%0h, expected no beat", s_rdata);
        end else begin
          mon_e = exp_r.pop_front();
          chk("s_rid", s_rid, mon_e.id);
          chk("s_rlast", s_rlast, mon_e.last);
          if (mon_e.err) begin
            chk("err_rdata", s_rdata, 0);
            chk("err_rresp", s_rresp, 2'b10);
          end else if (lite_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_without_lite: got data 0x%0h, expected a lite response first", s_rdata);
          end else begin
            mon_lv = lite_q.pop_front();
            chk("s_rdata", s_rdata, mon_lv[31:0]);
            chk("s_rresp", s_rresp, mon_lv[33:32]);
          end
          cur_beats++;
          if (mon_e.last) active = 1'b0;
        end
      end
      if (s_arvalid && s_arready) begin
        active    = 1'b1;
        cur_beats = 0;
        lat_chk   = (s_arburst != 2'b11) && (s_arsize <= 3'd2);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no completion, expected finish within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t;
    #12;
    chk("rst_s_arready", s_arready, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_s_rlast", s_rlast, 0);
    chk("rst_s_rdata", s_rdata, 0);
    chk("rst_s_rresp", s_rresp, 0);
    chk("rst_s_rid", s_rid, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    send_ar(32'h8000_0010, 4'h3, 8'd0, 3'd2, 2'b01);
    send_ar(32'h8000_0000, 4'h7, 8'd3, 3'd2, 2'b01);
    send_ar(32'h8000_0008, 4'h1, 8'd3, 3'd2, 2'b10);
    send_ar(32'h0000_1000, 4'h2, 8'd1, 3'd2, 2'b00);
    send_ar(32'h0000_0040, 4'h4, 8'd1, 3'd2, 2'b11);
    send_ar(32'h0000_0044, 4'h5, 8'd1, 3'd3, 2'b01);
    send_ar(32'hFFFF_FFF8, 4'h6, 8'd3, 3'd2, 2'b01);
    send_ar(32'h0000_0100, 4'h8, 8'd4, 3'd2, 2'b10);
    send_ar(32'h0000_003C, 4'h9, 8'd7, 3'd0, 2'b10);
    send_ar(32'h0000_0202, 4'hC, 8'd15, 3'd1, 2'b10);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  bu;
      logic [2:0]  sz;
      logic [7:0]  ln;
      logic [31:0] a;
      int          pick;
      bu = 2'($urandom_range(0, 3));
      if (bu == 2'b11 && $urandom_range(0, 3) != 0) bu = 2'b01;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if (bu == 2'b10) begin
        pick = $urandom_range(0, 4);
        case (pick)
          0: ln = 8'd1;
          1: ln = 8'd3;
          2: ln = 8'd7;
          3: ln = 8'd15;
          default: ln = 8'($urandom_range(0, 20));
        endcase
      end else begin
        ln = 8'($urandom_range(0, 15));
      end
      if (n == 20) begin bu = 2'b01; sz = 3'd2; ln = 8'hFF; end
      a = $urandom;
      if (sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      send_ar(a, 4'($urandom), ln, sz, bu);
    end
    drain();

    send_ar(32'h0000_2000, 4'hA, 8'd7, 3'd2, 2'b01);
    t = 0;
    @(negedge clock);
    while (!(cur_beats == 2 && s_rvalid) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 2000) begin
      checks++; errors++;
      $display("FAIL reset_setup_timeout: got %0d beats, expected beat 2 in flight", cur_beats);
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst_s_rvalid", s_rvalid, 0);
    chk("midrst_m_arvalid", m_arvalid, 0);
    chk("midrst_s_arready", s_arready, 0);
    chk("midrst_m_rready", m_rready, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    send_ar(32'h0000_3000, 4'hB, 8'd3, 3'd2, 2'b01);
    drain();

    chk("end_exp_addr_empty", exp_addr.size(), 0);
    chk("end_lite_q_empty", lite_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
